// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU32 datapath blocks: multiplier FSM states and
// the default operand width with its derived counter width.
package alu32_pkg;

  localparam int MUL_N     = 32;
  localparam int MUL_CNT_W = $clog2(MUL_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/addn_co.sv
// Combinational N-bit ripple-carry adder with carry-out and no carry-in.
// Built from full-adder cells so the carry chain is explicit.
module addn_co #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  // One full-adder cell per bit, carry rippling from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign co = carry[N];

endmodule

// File: rtl/mul32_seq.sv
// Sequential unsigned shift-add multiplier. One N-bit adder is reused for
// every partial product; a result is returned N+1 cycles after a start.
//
// Handshake: start is sampled at a rising edge and accepted only in IDLE or
// DONE; a and b are captured with an accepted start. busy is high for the N
// RUN cycles, done is a one-cycle pulse while in DONE, and product holds the
// result from the done cycle until the first RUN update of the next operation.
// start seen during RUN is ignored.
module mul32_seq
  import alu32_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output mul_state_t     state
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_t state_q, state_d;

  logic [N-1:0]     mcand;
  logic [N:0]       acc;    // carry bit plus upper half of the running product
  logic [N-1:0]     mq;     // lower half; starts as the multiplier
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic             step;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             co;

  // Partial-product select: add the multiplicand only when the current
  // multiplier bit is set.
  assign addend = mq[0] ? mcand : '0;

  addn_co #(.N(N)) u_add (
    .a   (acc[N-1:0]),
    .b   (addend),
    .sum (sum),
    .co  (co)
  );

  // Next-state and control decode; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they
  // come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Datapath: operand capture on an accepted start, one add-and-shift per
  // RUN cycle. The shifted-in top bit of acc is always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand <= a;
      mq    <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      acc     <= {1'b0, co, sum[N-1:1]};
      mq      <= {sum[0], mq[N-1:1]};
      cnt     <= cnt + 1'b1;
      product <= {co, sum, mq[N-1:1]};
    end
  end

  // The carry slot of acc is consumed by the shift every cycle, so it must
  // never hold a one between updates.
  acc_top_zero : assert property (@(posedge clk) disable iff (rst) acc[N] == 1'b0);

  assign state = state_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: table of directed products plus
// hand-written sequences for restart, ignored start and asynchronous reset.
module tb_mul32_seq;
  import alu32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  mul_state_t  state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] prev_prod;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] exp;
    int          poke_at;   // RUN cycle to pulse a stray start (0 = none)
  } vec_t;

  vec_t vecs[9];

  mul32_seq #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .state   (state)
  );

  // Clock and reset block: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation and follow it to the done pulse. Entry and exit are
  // on a falling edge with start low.
  task automatic run_mul(input logic [31:0] va, input logic [31:0] vb,
                         input logic [63:0] exp, input int poke_at);
    int cyc;
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("product_held_until_run", product, prev_prod);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == poke_at) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 64'(cyc), 64'd32);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("product", product, exp);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("no_restart", {63'd0, busy}, 64'd0);
    prev_prod = exp;
  endtask

  initial begin
    int cyc;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F, 0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0};
    vecs[2] = '{32'd0,         32'hDEAD_BEEF, 64'h0000_0000_0000_0000, 0};
    vecs[3] = '{32'd1,         32'h8000_0000, 64'h0000_0000_8000_0000, 0};
    vecs[4] = '{32'd7,         32'd6,         64'd42,                  10};
    vecs[5] = '{32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 0};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    prev_prod = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_state", {62'd0, state}, {62'd0, IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_mul(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].poke_at);
      @(negedge clk);
    end

    // Back-to-back: start held high through DONE, operands swapped after the
    // first capture.
    start = 1'b1;
    a     = 32'd2;
    b     = 32'd3;
    @(negedge clk);
    a = 32'd4;
    b = 32'd5;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("b2b_first_latency", 64'(cyc), 64'd32);
    check("b2b_first_product", product, 64'd6);
    @(negedge clk);
    check("b2b_no_idle", {63'd0, busy}, 64'd1);
    check("b2b_state_run", {62'd0, state}, {62'd0, RUN});
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_second_spacing", 64'(cyc), 64'd33);
    check("b2b_second_product", product, 64'd20);
    @(negedge clk);
    check("b2b_back_to_idle", {62'd0, state}, {62'd0, IDLE});
    prev_prod = 64'd20;
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1;
    a     = 32'h0000_FFFF;
    b     = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      cyc++;
      @(negedge clk);
    end
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_done", {63'd0, done}, 64'd0);
    check("async_reset_product", product, 64'd0);
    check("async_reset_state", {62'd0, state}, {62'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cyc++;
    end
    check("no_done_after_reset", 64'(cyc), 64'd0);
    prev_prod = '0;
    run_mul(32'd2, 32'd2, 64'd4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always reaches its summary.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential unsigned shift-add multiplier for the ALU32 datapath. It sits directly upstream of the ALU result mux and uses an N-bit ripple adder with carry-out once per cycle, so one adder serves all N partial products. A start/busy/done handshake loads two N-bit operands and returns a 2N-bit product after a fixed N+1 cycles.

## Interface
- N, 32: operand width; product width is 2N; N ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request; sampled at a rising edge, honoured only in IDLE or DONE.
- a  input  N  multiplicand; sampled with an accepted start.
- b  input  N  multiplier; sampled with an accepted start.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse; high while the state is DONE.
- product  output  2N  result; valid from the done cycle until the next accepted start.

## Operation
- States:
  - IDLE to RUN on start.
  - RUN to DONE when the cycle counter reaches N-1.
  - DONE to RUN on start, otherwise DONE to IDLE.
- Registers:
  - mcand holds N bits.
  - acc holds N+1 bits: carry plus upper half.
  - mq holds N bits: the lower half, initially the multiplier.
  - cnt holds ceil(log2 N) bits.
- On an accepted start:
  - mcand ← a, mq ← b, acc ← 0, cnt ← 0.
  - The product register is not cleared. It still shows the old value until the first RUN update.
- Each RUN cycle:
  - {co, s} = acc[N-1:0] + (mq[0] ? mcand : 0).
  - {acc, mq} ← {1'b0, co, s, mq} >> 1.
  - cnt increments. No adder carry-in; the top bit of acc is always 0 after the shift.
- Product path: product is {acc[N-1:0], mq}, driven from the registers. It equals a·b exactly, unsigned, with no overflow possible.
- start during RUN is ignored. Operands change only on an accepted start.
- start in DONE is accepted, and DONE goes directly to RUN. done still pulses for the old result.
- Reset:
  - Asserting rst at any time forces IDLE immediately.
  - Outputs go to busy=0, done=0, product=0, with mcand/acc/mq/cnt cleared.
  - An in-flight operation is discarded and no done is produced.
  - Deassertion is synchronised externally.

## Timing
- Latency:
  - With start accepted at edge T, busy is high after T through edge T+N.
  - DONE is entered at edge T+N, so done is high for exactly one cycle, between edges T+N and T+N+1.
  - product is valid from edge T+N.
- Throughput: with start held high, one result every N+1 cycles. Every state transition is edge-aligned.
- Glitch-free outputs: busy, done and product are pure register outputs with no combinational path from inputs.
- Critical path: one N-bit ripple add plus a 2:1 mux per cycle.

## Structure
- Shared package (alu32_pkg):
  - the state enum mul_state_t with IDLE, RUN and DONE;
  - the constant MUL_CNT_W = $clog2(N).
- Sub-module addn_co: a combinational N-bit ripple adder with inputs a, b and outputs sum, co, built from full-adder cells via generate. It is instantiated once.

## Test plan
- Latency: a=3, b=5, one-cycle start.
  - busy is high for 32 cycles, then done pulses once at cycle 33 after start.
  - product=0x0000_0000_0000_000F.
- Maximum operands: a=b=0xFFFF_FFFF gives product=0xFFFF_FFFE_0000_0001.
- Zero operand and identity:
  - a=0, b=0xDEAD_BEEF gives product=0.
  - a=1, b=0x8000_0000 gives product=0x0000_0000_8000_0000.
- start ignored during RUN: a=7, b=6 is accepted. At RUN cycle 10, start with a=9, b=9 is applied. Required: product=42, one done pulse, no restart.
- Back-to-back: start held high, giving 2×3 then 4×5.
  - done pulses for 6, RUN restarts without an IDLE cycle, and done pulses for 20 exactly 33 cycles later.
- Reset mid-operation: rst asserted at RUN cycle 15 (asynchronous, between edges).
  - busy, done and product go to 0 immediately, with no done.
  - A following 2×2 returns 4.
